alu_operand_issuer: RTL and testbench

//  Upstream neighbour of the ALU: accepts one decoded ALU instruction, fetches rs1/rs2 from the register file,

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_wait_timer.sv | 39 +++
 rtl/alu_operand_issuer.sv | 185 ++++++++++++++++++
 tb/tb_alu_operand_issuer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand issuer: default widths, FSM state
// encoding and the operand-select constants driven on rs_data_sel.
package alu_pkg;

   localparam int BUS_DEFAULT    = 32;
   localparam int OPCODE_DEFAULT = 11;
   localparam int REG_ADDR_W     = 5;

   localparam logic RS_SEL_RS1 = 1'b0;
   localparam logic RS_SEL_RS2 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_RS1,
      ST_SEND_RS1,
      ST_SEND_RS2,
      ST_WAIT_ALU
   } issuer_state_e;

endpackage

// File: rtl/alu_wait_timer.sv
// Cycle counter for the ALU wait window. Held at zero while clear_i is high,
// counts while enable_i is high, and flags the final allowed cycle.
module alu_wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Expiry is flagged during the TIMEOUT-th enabled cycle (count TIMEOUT-1).
   assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

   // Next count: clear wins, otherwise advance until the last cycle is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_operand_issuer.sv
// Issues one decoded ALU instruction at a time: reads rs1/rs2 from the
// register file, streams them over the shared rs_data bus, waits for the ALU
// result and emits a single writeback pulse to rd (suppressed for x0).
module alu_operand_issuer
   import alu_pkg::*;
#(
   parameter int BUS     = BUS_DEFAULT,
   parameter int OPCODE  = OPCODE_DEFAULT,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dec_valid,
   output logic                  dec_ready,
   input  logic [OPCODE-1:0]     dec_op_code,
   input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
   input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
   input  logic [REG_ADDR_W-1:0] dec_rd_addr,
   input  logic [BUS-1:0]        dec_imme,
   input  logic                  dec_use_imm,
   output logic [REG_ADDR_W-1:0] rf_raddr,
   input  logic [BUS-1:0]        rf_rdata,
   output logic [BUS-1:0]        imme_value,
   output logic [OPCODE-1:0]     op_code,
   output logic [BUS-1:0]        rs_data,
   output logic                  rs_data_sel,
   output logic                  rs_data_valid,
   input  logic [BUS-1:0]        alu_out,
   input  logic                  alu_valid_out,
   input  logic                  op_done,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_rd_addr,
   output logic [BUS-1:0]        wb_data,
   output logic                  busy,
   output logic                  err_timeout
);

   issuer_state_e         state_q, state_d;
   logic [OPCODE-1:0]     op_code_q, op_code_d;
   logic [BUS-1:0]        imme_q, imme_d;
   logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic                  use_imm_q, use_imm_d;
   logic [BUS-1:0]        rs_data_q, rs_data_d;
   logic                  rs_sel_q, rs_sel_d;
   logic                  rs_valid_q, rs_valid_d;
   logic                  got_q, got_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
   logic [BUS-1:0]        wb_data_q, wb_data_d;
   logic                  err_q, err_d;
   logic                  expired;

   alu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (state_q != ST_WAIT_ALU),
      .enable_i  (state_q == ST_WAIT_ALU),
      .expired_o (expired)
   );

   assign dec_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign imme_value    = imme_q;
   assign op_code       = op_code_q;
   assign rs_data       = rs_data_q;
   assign rs_data_sel   = rs_sel_q;
   assign rs_data_valid = rs_valid_q;
   assign wb_valid      = wb_valid_q;
   assign wb_rd_addr    = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign err_timeout   = err_q;

   // Next-state, register-file address and operand/writeback staging.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      op_code_d  = op_code_q;
      imme_d     = imme_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      use_imm_d  = use_imm_q;
      rs_data_d  = rs_data_q;
      rs_sel_d   = rs_sel_q;
      rs_valid_d = 1'b0;
      got_d      = got_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      err_d      = err_q;
      rf_raddr   = '0;

      unique case (state_q)
         ST_IDLE: begin
            got_d = 1'b0;
            if (dec_valid) begin
               op_code_d = dec_op_code;
               imme_d    = dec_imme;
               rs1_d     = dec_rs1_addr;
               rs2_d     = dec_rs2_addr;
               rd_d      = dec_rd_addr;
               use_imm_d = dec_use_imm;
               state_d   = ST_LOAD_RS1;
            end
         end
         ST_LOAD_RS1: begin
            rf_raddr   = rs1_q;
            rs_data_d  = (rs1_q == '0) ? '0 : rf_rdata;
            rs_sel_d   = RS_SEL_RS1;
            rs_valid_d = 1'b1;
            state_d    = ST_SEND_RS1;
         end
         ST_SEND_RS1: begin
            rf_raddr = rs2_q;
            if (!use_imm_q) begin
               rs_data_d  = (rs2_q == '0) ? '0 : rf_rdata;
               rs_sel_d   = RS_SEL_RS2;
               rs_valid_d = 1'b1;
               state_d    = ST_SEND_RS2;
            end else begin
               state_d = ST_WAIT_ALU;
            end
         end
         ST_SEND_RS2: begin
            state_d = ST_WAIT_ALU;
         end
         ST_WAIT_ALU: begin
            // Only the first result counts; a result arriving on the timeout
            // cycle is dropped unless op_done rescues it in the same cycle.
            if (alu_valid_out && !got_q && (op_done || !expired)) begin
               got_d      = 1'b1;
               wb_data_d  = alu_out;
               wb_rd_d    = rd_q;
               wb_valid_d = (rd_q != '0);
            end
            if (op_done) begin
               state_d = ST_IDLE;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_code_q  <= '0;
         imme_q     <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         use_imm_q  <= 1'b0;
         rs_data_q  <= '0;
         rs_sel_q   <= RS_SEL_RS1;
         rs_valid_q <= 1'b0;
         got_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_code_q  <= op_code_d;
         imme_q     <= imme_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         use_imm_q  <= use_imm_d;
         rs_data_q  <= rs_data_d;
         rs_sel_q   <= rs_sel_d;
         rs_valid_q <= rs_valid_d;
         got_q      <= got_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_alu_operand_issuer.sv
// Directed bench for alu_operand_issuer: a small register-file model, pulse
// monitors, and cycle-exact checks of operand streaming and writeback.
module tb_alu_operand_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_valid;
   logic        dec_ready;
   logic [10:0] dec_op_code;
   logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
   logic [31:0] dec_imme;
   logic        dec_use_imm;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic [31:0] imme_value;
   logic [10:0] op_code;
   logic [31:0] rs_data;
   logic        rs_data_sel;
   logic        rs_data_valid;
   logic [31:0] alu_out;
   logic        alu_valid_out;
   logic        op_done;
   logic        wb_valid;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        busy;
   logic        err_timeout;

   logic [31:0] rf [32];
   int n_checks = 0;
   int n_fail   = 0;
   int wb_cnt   = 0;
   int sel1_cnt = 0;
   int val_cnt  = 0;
   int snap_wb, snap_sel1, snap_val;

   always #5 clk = ~clk;

   assign rf_rdata = rf[rf_raddr];

   alu_operand_issuer #(.BUS(32), .OPCODE(11), .TIMEOUT(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .dec_op_code   (dec_op_code),
      .dec_rs1_addr  (dec_rs1_addr),
      .dec_rs2_addr  (dec_rs2_addr),
      .dec_rd_addr   (dec_rd_addr),
      .dec_imme      (dec_imme),
      .dec_use_imm   (dec_use_imm),
      .rf_raddr      (rf_raddr),
      .rf_rdata      (rf_rdata),
      .imme_value    (imme_value),
      .op_code       (op_code),
      .rs_data       (rs_data),
      .rs_data_sel   (rs_data_sel),
      .rs_data_valid (rs_data_valid),
      .alu_out       (alu_out),
      .alu_valid_out (alu_valid_out),
      .op_done       (op_done),
      .wb_valid      (wb_valid),
      .wb_rd_addr    (wb_rd_addr),
      .wb_data       (wb_data),
      .busy          (busy),
      .err_timeout   (err_timeout)
   );

   // Pulse monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (wb_valid) wb_cnt++;
      if (rs_data_valid) val_cnt++;
      if (rs_data_valid && rs_data_sel) sel1_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [10:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic use_imm);
      dec_valid    = 1'b1;
      dec_op_code  = op;
      dec_rs1_addr = r1;
      dec_rs2_addr = r2;
      dec_rd_addr  = rd;
      dec_imme     = imm;
      dec_use_imm  = use_imm;
   endtask

   task automatic alu_drive(input logic v, input logic d, input logic [31:0] res);
      alu_valid_out = v;
      op_done       = d;
      alu_out       = res;
   endtask

   task automatic snap();
      snap_wb   = wb_cnt;
      snap_sel1 = sel1_cnt;
      snap_val  = val_cnt;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
      rf[0] = 32'hDEAD_BEEF;
      rf[1] = 32'h0000_0010;
      rf[3] = 32'h0000_0005;
      rf[4] = 32'h0000_0007;
      rst_n = 1'b0;
      offer(11'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
      dec_valid = 1'b0;
      alu_drive(1'b0, 1'b0, 32'h0);

      // Reset state
      tick(); tick();
      check("rst_dec_ready", dec_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rs_valid", rs_data_valid, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_err", err_timeout, 0);
      check("rst_rf_raddr", rf_raddr, 0);
      check("rst_imme", imme_value, 0);
      rst_n = 1'b1;
      tick();

      // R-type: x5 = x3 op x4
      snap();
      offer(11'h003, 5'd3, 5'd4, 5'd5, 32'h0, 1'b0);
      tick();
      dec_valid = 1'b0;
      check("r_busy", busy, 1);
      check("r_dec_ready", dec_ready, 0);
      check("r_raddr_rs1", rf_raddr, 3);
      check("r_op_code", op_code, 11'h003);
      tick();
      check("r_rs1_valid", rs_data_valid, 1);
      check("r_rs1_sel", rs_data_sel, 0);
      check("r_rs1_data", rs_data, 32'h5);
      check("r_raddr_rs2", rf_raddr, 4);
      tick();
      check("r_rs2_valid", rs_data_valid, 1);
      check("r_rs2_sel", rs_data_sel, 1);
      check("r_rs2_data", rs_data, 32'h7);
      tick();
      check("r_wait_valid", rs_data_valid, 0);
      check("r_wait_hold", rs_data, 32'h7);
      check("r_wait_raddr", rf_raddr, 0);
      alu_drive(1'b1, 1'b1, 32'hC);
      tick();
      alu_drive(1'b0, 1'b0, 32'h0);
      check("r_wb_valid", wb_valid, 1);
      check("r_wb_rd", wb_rd_addr, 5);
      check("r_wb_data", wb_data, 32'hC);
      check("r_idle", dec_ready, 1);
      tick();
      check("r_wb_once", wb_cnt - snap_wb, 1);
      check("r_val_pulses", val_cnt - snap_val, 2);

      // I-type: x6 = x1 op imm, rs2 not sent; only first ALU result used
      snap();
      offer(11'h011, 5'd1, 5'd9, 5'd6, 32'hFFFF_FFF0, 1'b1);
      tick();
      dec_valid = 1'b0;
      check("i_imme", imme_value, 32'hFFFF_FFF0);
      tick();
      check("i_rs1_valid", rs_data_valid, 1);
      check("i_rs1_sel", rs_data_sel, 0);
      check("i_rs1_data", rs_data, 32'h10);
      tick();
      check("i_wait_valid", rs_data_valid, 0);
      check("i_wait_busy", busy, 1);
      tick(); tick();
      check("i_imme_held", imme_value, 32'hFFFF_FFF0);
      alu_drive(1'b1, 1'b0, 32'h1234);
      tick();
      check("i_wb_valid", wb_valid, 1);
      check("i_wb_data", wb_data, 32'h1234);
      check("i_wb_rd", wb_rd_addr, 6);
      check("i_still_busy", busy, 1);
      alu_drive(1'b1, 1'b1, 32'h5555);
      tick();
      alu_drive(1'b0, 1'b0, 32'h0);
      check("i_second_ignored", wb_valid, 0);
      check("i_wb_data_kept", wb_data, 32'h1234);
      check("i_idle", dec_ready, 1);
      check("i_no_sel1", sel1_cnt - snap_sel1, 0);
      check("i_one_pulse", val_cnt - snap_val, 1);

      // x0: rs1=x0 reads as zero, rd=x0 suppresses writeback
      snap();
      offer(11'h001, 5'd0, 5'd4, 5'd0, 32'h0, 1'b0);
      tick();
      dec_valid = 1'b0;
      tick();
      check("x0_rs1_data", rs_data, 32'h0);
      check("x0_rs1_valid", rs_data_valid, 1);
      tick();
      check("x0_rs2_data", rs_data, 32'h7);
      tick();
      alu_drive(1'b1, 1'b1, 32'h77);
      tick();
      alu_drive(1'b0, 1'b0, 32'h0);
      check("x0_no_wb", wb_valid, 0);
      check("x0_idle", dec_ready, 1);
      tick();
      check("x0_wb_count", wb_cnt - snap_wb, 0);

      // op_done on the 8th WAIT_ALU cycle beats the timeout
      offer(11'h002, 5'd3, 5'd4, 5'd7, 32'h0, 1'b0);
      tick();
      dec_valid = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 7; i++) tick();
      check("od8_busy", busy, 1);
      alu_drive(1'b0, 1'b1, 32'h0);
      tick();
      alu_drive(1'b0, 1'b0, 32'h0);
      check("od8_no_err", err_timeout, 0);
      check("od8_idle", dec_ready, 1);

      // Silent ALU: timeout after 8 WAIT_ALU cycles, no writeback
      snap();
      offer(11'h002, 5'd3, 5'd4, 5'd7, 32'h0, 1'b0);
      tick();
      dec_valid = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 7; i++) tick();
      check("to_busy_c8", busy, 1);
      check("to_no_err_c8", err_timeout, 0);
      tick();
      check("to_err", err_timeout, 1);
      check("to_idle", dec_ready, 1);
      tick(); tick();
      check("to_sticky", err_timeout, 1);
      check("to_no_wb", wb_cnt - snap_wb, 0);

      // Same-cycle result+done, then back-to-back instruction
      snap();
      offer(11'h004, 5'd3, 5'd4, 5'd8, 32'h0, 1'b0);
      tick();
      dec_valid = 1'b0;
      tick(); tick(); tick();
      alu_drive(1'b1, 1'b1, 32'hAB);
      offer(11'h005, 5'd4, 5'd1, 5'd9, 32'h0, 1'b0);
      tick();
      alu_drive(1'b0, 1'b0, 32'h0);
      check("b2b_wb_valid", wb_valid, 1);
      check("b2b_wb_data", wb_data, 32'hAB);
      check("b2b_wb_rd", wb_rd_addr, 8);
      check("b2b_ready", dec_ready, 1);
      tick();
      dec_valid = 1'b0;
      check("b2b_accepted", dec_ready, 0);
      check("b2b_raddr", rf_raddr, 4);
      check("b2b_op_code", op_code, 11'h005);
      tick();
      check("b2b_rs1_data", rs_data, 32'h7);
      check("b2b_rs1_sel", rs_data_sel, 0);
      tick();
      check("b2b_rs2_data", rs_data, 32'h10);
      check("b2b_rs2_sel", rs_data_sel, 1);
      tick();
      alu_drive(1'b0, 1'b1, 32'h0);
      tick();
      alu_drive(1'b0, 1'b0, 32'h0);
      check("b2b_done_no_wb", wb_valid, 0);
      tick();
      check("b2b_wb_count", wb_cnt - snap_wb, 1);

      // Reset during SEND_RS1 aborts cleanly
      offer(11'h006, 5'd3, 5'd4, 5'd10, 32'h1, 1'b0);
      tick();
      dec_valid = 1'b0;
      tick();
      check("mr_in_send", rs_data_valid, 1);
      rst_n = 1'b0;
      tick();
      check("mr_ready", dec_ready, 1);
      check("mr_busy", busy, 0);
      check("mr_valid", rs_data_valid, 0);
      check("mr_rs_data", rs_data, 0);
      check("mr_op_code", op_code, 0);
      check("mr_imme", imme_value, 0);
      check("mr_wb_data", wb_data, 0);
      check("mr_err_cleared", err_timeout, 0);
      check("mr_raddr", rf_raddr, 0);
      rst_n = 1'b1;
      snap();
      for (int i = 0; i < 6; i++) tick();
      check("mr_no_stray_val", val_cnt - snap_val, 0);
      check("mr_no_stray_wb", wb_cnt - snap_wb, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
